updown_counter_param: RTL



---
 rtl/updown_counter_pkg.sv | 23 ++
 rtl/updown_counter_next.sv | 55 +++++
 rtl/updown_counter_param.sv | 78 +++++++
 3 files changed

// File: rtl/updown_counter_pkg.sv
// Shared constants and helpers for the parametrised up/down counter.
// Optional build macro: SATURATE_EN (saturate at the bounds instead of wrapping).
package updown_counter_pkg;

    localparam logic DIR_UP   = 1'b1;
    localparam logic DIR_DOWN = 1'b0;

    // Largest count value, masked to the counter width so MODULUS = 2**WIDTH
    // yields all ones rather than needing a wider intermediate.
    function automatic logic [63:0] max_count(input int unsigned width,
                                              input logic [63:0] modulus);
        logic [63:0] mask;
        mask = (64'd1 << width) - 64'd1;
        return (modulus - 64'd1) & mask;
    endfunction

    // Out-of-range load values park the counter at its top value.
    function automatic logic [63:0] clamp_load(input logic [63:0] din,
                                               input logic [63:0] max_v);
        return (din > max_v) ? max_v : din;
    endfunction

endpackage

// File: rtl/updown_counter_next.sv
// Combinational next-count and bound-hit logic for updown_counter_param.
// Optional build macro: SATURATE_EN (hold at the bound instead of wrapping).
module updown_counter_next
    import updown_counter_pkg::*;
#(
    parameter int unsigned WIDTH   = 4,
    parameter int unsigned MODULUS = 2**WIDTH
) (
    input  logic [WIDTH-1:0] q,
    input  logic             en,
    input  logic             up_dn,
    output logic [WIDTH-1:0] next_q,
    output logic             bound_hit
);

    localparam logic [WIDTH-1:0] MAX_Q = WIDTH'(max_count(WIDTH, 64'(MODULUS)));

    logic out_of_range;

    // Extra leading bit keeps the compare meaningful when MAX_Q is all ones.
    assign out_of_range = {1'b0, q} > {1'b0, MAX_Q};

    always_comb begin
        next_q    = q;
        bound_hit = 1'b0;
        if (en) begin
            if (out_of_range) begin
                next_q = '0;
            end else if (up_dn == DIR_UP) begin
                if (q == MAX_Q) begin
                    bound_hit = 1'b1;
`ifdef SATURATE_EN
                    next_q = q;
`else
                    next_q = '0;
`endif
                end else begin
                    next_q = q + WIDTH'(1);
                end
            end else begin
                if (q == '0) begin
                    bound_hit = 1'b1;
`ifdef SATURATE_EN
                    next_q = q;
`else
                    next_q = MAX_Q;
`endif
                end else begin
                    next_q = q - WIDTH'(1);
                end
            end
        end
    end

endmodule

// File: rtl/updown_counter_param.sv
// Parametrised synchronous up/down counter with preset, load and terminal count.
// Optional build macro: SATURATE_EN (saturate at the bounds instead of wrapping).
module updown_counter_param
    import updown_counter_pkg::*;
#(
    parameter int unsigned WIDTH   = 4,
    parameter int unsigned MODULUS = 2**WIDTH
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             pre,
    input  logic             en,
    input  logic             up_dn,
    input  logic             load,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] q_bar,
    output logic             tc,
    output logic             wrap
);

    localparam logic [WIDTH-1:0] MAX_Q = WIDTH'(max_count(WIDTH, 64'(MODULUS)));

    logic [WIDTH-1:0] next_q;
    logic             bound_hit;
    logic             wrap_set;

    updown_counter_next #(
        .WIDTH   (WIDTH),
        .MODULUS (MODULUS)
    ) u_next (
        .q         (q),
        .en        (en),
        .up_dn     (up_dn),
        .next_q    (next_q),
        .bound_hit (bound_hit)
    );

`ifdef SATURATE_EN
    // Remembers that the last enabled edge already hit the bound, so a parked
    // counter reports the saturation only once.
    logic parked;

    always_ff @(posedge clk) begin
        if (clr || pre || load)
            parked <= 1'b0;
        else if (en)
            parked <= bound_hit;
    end

    assign wrap_set = bound_hit & ~parked;
`else
    assign wrap_set = bound_hit;
`endif

    always_ff @(posedge clk) begin
        if (clr) begin
            q    <= '0;
            wrap <= 1'b0;
        end else if (pre) begin
            q    <= MAX_Q;
            wrap <= 1'b0;
        end else if (load) begin
            q    <= WIDTH'(clamp_load(64'(din), 64'(MAX_Q)));
            wrap <= 1'b0;
        end else if (en) begin
            q    <= next_q;
            wrap <= wrap_set;
        end else begin
            wrap <= 1'b0;
        end
    end

    assign q_bar = ~q;
    assign tc    = en & (((up_dn == DIR_UP)   && (q == MAX_Q)) ||
                         ((up_dn == DIR_DOWN) && (q == '0)));

endmodule
